univ_shift_reg_p: RTL and testbench
===================================

UNIV_SHIFT_REG_P -- requirements
Module: univ_shift_reg_p

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of the burst count field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-005 mode  input  3  operation select, encoding per REQ-012.
REQ-006 data_in  input  WIDTH  parallel load value.
REQ-007 msb_in / lsb_in  input  1 each  serial fill bits for SHR / SHL.
REQ-008 start  input  1  request a multi-step burst of the selected shift/rotate.
REQ-009 count  input  CW  number of steps in a burst, 0..WIDTH.
REQ-010 data_out  output  WIDTH  register contents; msb_out / lsb_out  output  1 each  = data_out[WIDTH-1] / data_out[0], combinational from the register.
REQ-011 busy  output  1  burst in progress; done  output  1  one-cycle burst-complete pulse.

Function
REQ-012 mode encoding SHALL be: 0 HOLD, 1 SHR (msb_in enters MSB), 2 SHL (lsb_in enters LSB), 3 LOAD, 4 ROTR, 5 ROTL, 6 ASHR (MSB replicated), 7 CLEAR (all zero).
REQ-013 With busy=0 and start=0, the selected operation SHALL be applied once at the next rising edge (latency 1 cycle).
REQ-014 FSM SHALL have states IDLE, BUSY, DONE; busy=1 only in BUSY, done=1 only in DONE.
REQ-015 IDLE, start=1, mode in {SHR,SHL,ROTR,ROTL,ASHR}, count>0: latch mode and count, apply first step that same edge, go BUSY if count>1 else DONE.
REQ-016 BUSY: one latched step per cycle; go DONE on the edge performing the last step; total steps = latched count exactly.
REQ-017 IDLE, start=1, count=0 with a shift mode: no register change, go DONE next edge.
REQ-018 start=1 with HOLD, LOAD or CLEAR SHALL be a plain single-cycle operation; FSM stays IDLE.
REQ-019 DONE lasts exactly one cycle, then IDLE; mode/start in DONE cycle are processed as in IDLE.
REQ-020 While BUSY, mode, start, count, data_in SHALL be ignored; msb_in/lsb_in SHALL be sampled live each step.
REQ-021 count>WIDTH SHALL be saturated to WIDTH.

Reset
REQ-022 rst=1 at a clock edge SHALL force data_out=0, state IDLE, busy=0, done=0, internal counter=0, overriding any operation, including mid-burst.
REQ-023 First edge after rst deasserts SHALL process inputs as in IDLE.

Configuration
REQ-024 Macro USR_PARITY_EN defined: add output parity (1 bit) = XOR of data_out, registered together with data_out (same cycle as data_out change); reset 0.
REQ-025 USR_PARITY_EN undefined: no parity port, no parity logic.

Structure
REQ-026 Package usr_pkg SHALL hold the mode enum (usr_mode_e, 3 bits), the FSM state enum, and the mode encoding constants.
REQ-027 Sub-module usr_burst_ctrl SHALL contain the FSM and step counter, outputting a step-enable and latched mode; datapath stays in univ_shift_reg_p.

Verification (WIDTH=8)
REQ-028 LOAD 8'hA5, then SHR with msb_in=1 -> data_out=8'hD2 after 1 cycle, msb_out=1, lsb_out=0.
REQ-029 data_out=8'h81, start, ROTL, count=3 -> busy 2 cycles, 8'h0C after 3rd edge, done pulse 1 cycle, then 8'h0C held with HOLD.
REQ-030 data_out=8'h80, start, ASHR, count=9 -> saturates to 8 steps, result 8'hFF, done once.
REQ-031 Burst SHL count=5 from 8'h01, rst asserted after 2nd step -> data_out=0, busy=0, done never pulses.
REQ-032 start with count=0, mode SHR -> data_out unchanged, done pulses next cycle, busy never 1; start during BUSY ignored (step total unchanged).
REQ-033 USR_PARITY_EN defined: LOAD 8'h07 -> parity=1 same cycle data_out=8'h07; CLEAR -> parity=0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and
// burst FSM states.
package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    M_HOLD  = 3'd0,
    M_SHR   = 3'd1,
    M_SHL   = 3'd2,
    M_LOAD  = 3'd3,
    M_ROTR  = 3'd4,
    M_ROTL  = 3'd5,
    M_ASHR  = 3'd6,
    M_CLEAR = 3'd7
  } usr_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } usr_state_e;

  // Only shifts and rotates can be repeated as a burst.
  function automatic logic is_burst_mode(usr_mode_e m);
    return m inside {M_SHR, M_SHL, M_ROTR, M_ROTL, M_ASHR};
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: tracks remaining steps and tells the datapath
// when and which operation to apply each cycle.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  usr_mode_e     mode,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          step_en,
  output usr_mode_e     step_mode,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] CMAX = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  usr_state_e    state;
  usr_mode_e     mode_q;
  logic [CW-1:0] rem_q;
  logic [CW-1:0] cnt_sat;
  logic          burst_req;

  assign cnt_sat   = (count > CMAX) ? CMAX : count;
  assign burst_req = (state != S_BUSY) && start
                   && is_burst_mode(mode);

  always_comb begin
    step_en   = 1'b1;
    step_mode = mode;
    if (state == S_BUSY) begin
      step_mode = mode_q;
    end else if (burst_req) begin
      step_en = (cnt_sat != '0);
    end
  end

  // rem_q holds the steps still owed, including the one taken this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= M_HOLD;
      rem_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        S_BUSY: begin
          if (rem_q == ONE) begin
            state <= S_DONE;
            rem_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            rem_q <= rem_q - ONE;
          end
        end
        default: begin
          if (burst_req) begin
            mode_q <= mode;
            if (cnt_sat > ONE) begin
              state <= S_BUSY;
              rem_q <= cnt_sat - ONE;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= S_DONE;
              rem_q <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
            rem_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/univ_shift_reg_p.sv
// Universal shift register with multi-step bursts.
// Define USR_PARITY_EN to add a registered parity output.
module univ_shift_reg_p
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] data_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  usr_mode_e        mode_e;
  usr_mode_e        step_mode;
  logic             step_en;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d_next;

  assign mode_e = usr_mode_e'(mode);

  usr_burst_ctrl #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode_e),
    .start    (start),
    .count    (count),
    .step_en  (step_en),
    .step_mode(step_mode),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    d_next = q;
    if (step_en) begin
      unique case (step_mode)
        M_HOLD:  d_next = q;
        M_SHR:   d_next = {msb_in, q[WIDTH-1:1]};
        M_SHL:   d_next = {q[WIDTH-2:0], lsb_in};
        M_LOAD:  d_next = data_in;
        M_ROTR:  d_next = {q[0], q[WIDTH-1:1]};
        M_ROTL:  d_next = {q[WIDTH-2:0], q[WIDTH-1]};
        M_ASHR:  d_next = {q[WIDTH-1], q[WIDTH-1:1]};
        M_CLEAR: d_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d_next;
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity <= 1'b0;
    else     parity <= ^d_next;
  end
`endif

  assign data_out = q;
  assign msb_out  = q[WIDTH-1];
  assign lsb_out  = q[0];

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Self-checking bench for univ_shift_reg_p (WIDTH=8): directed
// scenarios plus randomized traffic against an arithmetic model.
module tb_univ_shift_reg_p;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    mode;
  logic [W-1:0]  data_in;
  logic          msb_in, lsb_in, start;
  logic [CW-1:0] count;
  logic [W-1:0]  data_out;
  logic          msb_out, lsb_out, busy, done;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] m_v;
  int           m_rem;
  logic [2:0]   m_lm;
  logic         m_busy, m_done;

  univ_shift_reg_p #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .data_in (data_in),
    .msb_in  (msb_in),
    .lsb_in  (lsb_in),
    .start   (start),
    .count   (count),
    .data_out(data_out),
    .msb_out (msb_out),
    .lsb_out (lsb_out),
    .busy    (busy),
    .done    (done)
`ifdef USR_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] apply(logic [2:0] md, logic [W-1:0] v,
                                         logic mi, logic li,
                                         logic [W-1:0] d);
    logic [W-1:0] r;
    case (md)
      3'd0: r = v;
      3'd1: r = (v >> 1) | (W'(mi) << (W - 1));
      3'd2: r = (v << 1) | W'(li);
      3'd3: r = d;
      3'd4: r = (v >> 1) | (v << (W - 1));
      3'd5: r = (v << 1) | (v >> (W - 1));
      3'd6: r = W'($signed(v) >>> 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit is_shift(logic [2:0] md);
    return md inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
  endfunction

  // One clock: the model consumes the inputs present at the edge.
  task automatic tick();
    int n;
    @(posedge clk);
    if (rst) begin
      m_v = '0; m_rem = 0; m_busy = 0; m_done = 0;
    end else if (m_rem > 0) begin
      m_v    = apply(m_lm, m_v, msb_in, lsb_in, data_in);
      m_rem  = m_rem - 1;
      m_busy = (m_rem > 0);
      m_done = (m_rem == 0);
    end else if (start && is_shift(mode)) begin
      n    = (int'(count) > W) ? W : int'(count);
      m_lm = mode;
      if (n > 0) begin
        m_v   = apply(mode, m_v, msb_in, lsb_in, data_in);
        m_rem = n - 1;
      end else begin
        m_rem = 0;
      end
      m_busy = (m_rem > 0);
      m_done = (m_rem == 0);
    end else begin
      m_v    = apply(mode, m_v, msb_in, lsb_in, data_in);
      m_busy = 0;
      m_done = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; mode = 3'd0; start = 0; count = '0;
    data_in = '0; msb_in = 0; lsb_in = 0;
  endtask

  task automatic load(logic [W-1:0] v);
    idle_inputs();
    mode = 3'd3; data_in = v;
    tick();
    mode = 3'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; mode = 3'd3; data_in = 8'hFF; start = 1; count = 4'd3;
    tick();
    tick();
    vectors++;
    if ({data_out, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: data=%h busy=%b done=%b want 00/0/0",
               data_out, busy, done);
    end
    idle_inputs();
  endtask

  task automatic test_load_shr();
    load(8'hA5);
    vectors++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL load: got %h want a5", data_out);
    end
    mode = 3'd1; msb_in = 1;
    tick();
    vectors++;
    if ({data_out, msb_out, lsb_out} !== {8'hD2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL shr: got %h msb=%b lsb=%b want d2/1/0",
               data_out, msb_out, lsb_out);
    end
    idle_inputs();
  endtask

  task automatic test_rotl_burst();
    int nb, nd;
    load(8'h81);
    mode = 3'd5; start = 1; count = 4'd3;
    nb = 0; nd = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      mode = 3'd0; start = 0;
      nb += int'(busy);
      nd += int'(done);
      if (i == 3) begin
        vectors++;
        if ({data_out, done} !== {8'h0C, 1'b1}) begin
          errors++;
          $display("FAIL rotl_3rd: got %h done=%b want 0c/1",
                   data_out, done);
        end
      end
    end
    vectors++;
    if (nb != 2 || nd != 1 || data_out !== 8'h0C) begin
      errors++;
      $display("FAIL rotl_burst: busy=%0d done=%0d data=%h want 2/1/0c",
               nb, nd, data_out);
    end
  endtask

  task automatic test_ashr_sat();
    int nb, nd;
    load(8'h80);
    mode = 3'd6; start = 1; count = 4'd9;
    nb = 0; nd = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      mode = 3'd0; start = 0;
      nb += int'(busy);
      nd += int'(done);
    end
    vectors++;
    if (nb != 7 || nd != 1 || data_out !== 8'hFF) begin
      errors++;
      $display("FAIL ashr_sat: busy=%0d done=%0d data=%h want 7/1/ff",
               nb, nd, data_out);
    end
  endtask

  task automatic test_reset_mid_burst();
    int nd;
    load(8'h01);
    mode = 3'd2; start = 1; count = 4'd5;
    tick();
    start = 0;
    tick();
    vectors++;
    if ({data_out, busy} !== {8'h04, 1'b1}) begin
      errors++;
      $display("FAIL shl_2steps: got %h busy=%b want 04/1",
               data_out, busy);
    end
    rst = 1;
    tick();
    rst = 0; mode = 3'd0;
    nd = int'(done);
    vectors++;
    if ({data_out, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL mid_rst: got %h busy=%b want 00/0", data_out, busy);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      nd += int'(done | busy);
    end
    vectors++;
    if (nd != 0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_after: done/busy=%0d data=%h want 0/00",
               nd, data_out);
    end
  endtask

  task automatic test_zero_count_and_busy_start();
    load(8'h3C);
    mode = 3'd1; start = 1; count = '0; msb_in = 1;
    tick();
    mode = 3'd0; start = 0;
    vectors++;
    if ({data_out, busy, done} !== {8'h3C, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_cnt: got %h busy=%b done=%b want 3c/0/1",
               data_out, busy, done);
    end
    tick();
    vectors++;
    if ({data_out, busy, done} !== {8'h3C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zero_cnt_after: got %h busy=%b done=%b want 3c/0/0",
               data_out, busy, done);
    end
    load(8'h01);
    mode = 3'd2; start = 1; count = 4'd4; lsb_in = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mode = 3'd5; data_in = 8'hEE; count = 4'd8;
    end
    start = 0; mode = 3'd0;
    vectors++;
    if ({data_out, done} !== {8'h10, 1'b1}) begin
      errors++;
      $display("FAIL busy_start: got %h done=%b want 10/1",
               data_out, done);
    end
  endtask

`ifdef USR_PARITY_EN
  task automatic test_parity();
    load(8'h07);
    vectors++;
    if ({data_out, parity} !== {8'h07, 1'b1}) begin
      errors++;
      $display("FAIL parity_load: got %h p=%b want 07/1",
               data_out, parity);
    end
    mode = 3'd7;
    tick();
    vectors++;
    if ({data_out, parity} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL parity_clear: got %h p=%b want 00/0",
               data_out, parity);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic ok;
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 40) == 0);
      mode    = 3'($urandom_range(0, 7));
      start   = ($urandom_range(0, 2) == 0);
      count   = CW'($urandom_range(0, 15));
      data_in = W'($urandom);
      msb_in  = 1'($urandom);
      lsb_in  = 1'($urandom);
      tick();
      ok = ({data_out, msb_out, lsb_out, busy, done} ===
            {m_v, m_v[W-1], m_v[0], m_busy, m_done});
`ifdef USR_PARITY_EN
      ok = ok && (parity === ^m_v);
`endif
      vectors++;
      if (!ok) begin
        errors++;
        $display("FAIL rand[%0d]: data=%h b=%b d=%b want %h/%b/%b",
                 i, data_out, busy, done, m_v, m_busy, m_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_v = '0; m_rem = 0; m_lm = 3'd0; m_busy = 0; m_done = 0;
    test_reset();
    test_load_shr();
    test_rotl_burst();
    test_ashr_sat();
    test_reset_mid_burst();
    test_zero_count_and_busy_start();
`ifdef USR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
